seven_segment_scheduler: RTL and testbench

//   Drives the two-digit seven-segment PMOD (7 shared segment lines, 1 digit-select line).

---
 rtl/seven_segment_scheduler.sv | 85 ++++++++
 tb/tb_seven_segment_scheduler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_scheduler.sv
// seven_segment_scheduler: two-digit seven-segment multiplexer with dead-time blanking,
// 16-level PWM brightness and frame-synchronous loading of new digit patterns.
module seven_segment_scheduler #(
    parameter int DIVIDER      = 1500,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [6:0] i_segments_digit_0,
    input  logic [6:0] i_segments_digit_1,
    input  logic       i_load_valid,
    output logic       o_load_ready,
    input  logic [3:0] i_brightness,
    output logic [6:0] o_sev_segments,
    output logic       o_sev_seg_cathode,
    output logic       o_frame_start
);
    localparam int CW = $clog2(DIVIDER);
    localparam logic [CW-1:0] SHOW_END = CW'(DIVIDER - BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(DIVIDER - 1);

    typedef enum logic [2:0] {IDLE, SHOW0, GAP0, SHOW1, GAP1} state_t;

    state_t        state;
    logic [CW-1:0] c;
    logic [6:0]    active_0, active_1, pending_0, pending_1;
    logic          pending;
    logic [3:0]    brightness;
    logic          load, boundary, lit;

    assign load     = i_load_valid && o_load_ready;
    assign boundary = i_enable && (state == IDLE || (state == GAP1 && c == SLOT_END));
    assign lit      = c[3:0] <= brightness;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state             <= IDLE;
            c                 <= '0;
            o_sev_segments    <= 7'h7F;
            o_sev_seg_cathode <= 1'b0;
            o_load_ready      <= 1'b1;
            o_frame_start     <= 1'b0;
            active_0          <= '0;
            active_1          <= '0;
            pending_0         <= '0;
            pending_1         <= '0;
            pending           <= 1'b0;
            brightness        <= '0;
        end else begin
            if (load) begin
                pending_0 <= i_segments_digit_0;
                pending_1 <= i_segments_digit_1;
            end
            if (boundary) begin
                brightness <= i_brightness;
                if (pending) begin
                    active_0 <= pending_0;
                    active_1 <= pending_1;
                end
            end
            pending <= load || (pending && !boundary);
            // ready reopens one cycle after the frame_start pulse of the frame that consumed the load
            o_load_ready      <= !load && (o_load_ready || (o_frame_start && !pending));
            o_frame_start     <= i_enable && state == SHOW0 && c == '0;
            o_sev_seg_cathode <= i_enable && (state == SHOW1 || state == GAP1);
            o_sev_segments    <= (!i_enable || !lit) ? 7'h7F :
                                 state == SHOW0 ? ~active_0 :
                                 state == SHOW1 ? ~active_1 : 7'h7F;
            if (!i_enable) begin
                state <= IDLE;
                c     <= '0;
            end else begin
                c <= (state == IDLE || c == SLOT_END) ? '0 : c + 1'b1;
                case (state)
                    IDLE:    state <= SHOW0;
                    SHOW0:   if (c == SHOW_END) state <= GAP0;
                    GAP0:    if (c == SLOT_END) state <= SHOW1;
                    SHOW1:   if (c == SHOW_END) state <= GAP1;
                    default: if (c == SLOT_END) state <= SHOW0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_scheduler.sv
// tb_seven_segment_scheduler: randomized scoreboard bench; a frame-position model predicts every pin each cycle.
module tb_seven_segment_scheduler;
    localparam int D = 40, B = 4;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0;
    logic [6:0] d0 = '0, d1 = '0, segs;
    logic [3:0] br = '0;
    logic       ready, cath, fs;
    int         total = 0, bad = 0;

    seven_segment_scheduler #(.DIVIDER(D), .BLANK_CYCLES(B)) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .i_segments_digit_0(d0), .i_segments_digit_1(d1),
        .i_load_valid(valid), .o_load_ready(ready), .i_brightness(br),
        .o_sev_segments(segs), .o_sev_seg_cathode(cath), .o_frame_start(fs)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [6:0] segs; logic cath; logic fs; logic ready;} exp_t;
    exp_t       expq[$];
    int         k = -1, cd = 0;
    logic [6:0] act[2], pend_d[2];
    logic       m_pend = 1'b0, m_ready = 1'b1;
    logic [3:0] m_br = '0;

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: k is the position within an 80-cycle frame, -1 when idle
    always @(posedge clk) begin
        exp_t e;
        logic hs, bnd;
        int   slot, w;
        e.segs = 7'h7F; e.cath = 1'b0; e.fs = 1'b0;
        if (rst) begin
            k = -1; cd = 0; m_pend = 1'b0; m_ready = 1'b1; m_br = '0;
            act[0] = '0; act[1] = '0; pend_d[0] = '0; pend_d[1] = '0;
        end else begin
            hs  = valid && m_ready;
            bnd = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) m_ready = 1'b1;
            end
            if (!en) k = -1;
            else if (k < 0) begin
                k = 0;
                bnd = 1'b1;
            end else begin
                slot   = k / D;
                w      = k % D;
                e.cath = slot == 1;
                e.fs   = k == 0;
                if (w < D - B && (w % 16) <= int'(m_br)) e.segs = ~act[slot];
                k   = (k + 1) % (2 * D);
                bnd = k == 0;
            end
            if (bnd) begin
                m_br = br;
                if (m_pend) begin
                    act[0] = pend_d[0]; act[1] = pend_d[1];
                    m_pend = 1'b0;
                    cd = 2;
                end
            end
            if (hs) begin
                pend_d[0] = d0; pend_d[1] = d1;
                m_pend = 1'b1; m_ready = 1'b0;
            end
        end
        e.ready = m_ready;
        expq.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue want entry at %0t", $time);
        end else begin
            e = expq.pop_front();
            chk("segments", segs, e.segs);
            chk("cathode", 7'(cath), 7'(e.cath));
            chk("frame_start", 7'(fs), 7'(e.fs));
            chk("ready", 7'(ready), 7'(e.ready));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (k != p && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (k != p) begin
            total++; bad++;
            $display("FAIL wait_pos: got %0d want %0d", k, p);
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(20);
        d0 = 7'h3F; d1 = 7'h06; br = 4'd15; valid = 1'b1;
        step(1);
        valid = 1'b0; en = 1'b1;
        step(200);
        br = 4'd3;
        step(170);
        wait_pos(20);
        d0 = 7'h5B; d1 = 7'h4F; valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(3);
        d0 = 7'h66; d1 = 7'h6D; valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(170);
        wait_pos(50);
        en = 1'b0;
        step(5);
        en = 1'b1;
        step(100);
        wait_pos(10);
        rst = 1'b1;
        #1;
        chk("async_reset_segments", segs, 7'h7F);
        chk("async_reset_cathode", 7'(cath), 7'd0);
        chk("async_reset_ready", 7'(ready), 7'd1);
        step(2);
        rst = 1'b0;
        step(50);
        for (int i = 0; i < 1500; i++) begin
            valid = $urandom_range(0, 9) == 0;
            d0 = 7'($urandom);
            d1 = 7'($urandom);
            if ($urandom_range(0, 99) == 0) br = 4'($urandom);
            step(1);
        end
        valid = 1'b0;
        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
